// File: rtl/div_seq.sv
// Multi-cycle radix-2 divider, one quotient bit per cycle, signed/unsigned, with annul.
// Optional leading-zero early termination when DIV_SEQ_EARLY_OUT_EN is defined.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BYZERO = 3'd1;
  localparam logic [2:0] S_ON     = 3'd2;
  localparam logic [2:0] S_CORR   = 3'd3;
  localparam logic [2:0] S_END    = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic               zdiv_q, zdiv_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d, busy_q, busy_d, dz_q, dz_d;

  logic               sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     partial, diff;

`ifdef DIV_SEQ_EARLY_OUT_EN
  function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
    lzc = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) lzc = CW'(WIDTH - 1 - i);
  endfunction
  logic [CW-1:0] lz;
  assign lz = lzc(mag1);
`endif

  assign sign1 = signed_div_i & opdata1_i[WIDTH-1];
  assign sign2 = signed_div_i & opdata2_i[WIDTH-1];
  assign mag1  = sign1 ? -opdata1_i : opdata1_i;
  assign mag2  = sign2 ? -opdata2_i : opdata2_i;

  // quo_q shifts the dividend out of its MSB while quotient bits enter at the LSB
  assign partial = {rem_q, quo_q[WIDTH-1]};
  assign diff    = partial - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    zdiv_d   = zdiv_q;
    result_d = result_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          busy_d = 1'b1;
          dvs_d  = mag2;
          rem_d  = '0;
          qneg_d = sign1 ^ sign2;
          rneg_d = sign1;
          zdiv_d = 1'b0;
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
            zdiv_d  = 1'b1;
            quo_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
`ifdef DIV_SEQ_EARLY_OUT_EN
            if (mag1 == '0) begin
              state_d = S_BYZERO;
              quo_d   = '0;
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
            end else begin
              state_d = S_ON;
              quo_d   = mag1 << lz;
              cnt_d   = lz;
            end
`else
            state_d = S_ON;
            quo_d   = mag1;
            cnt_d   = '0;
`endif
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_CORR;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = partial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_CORR;
        end
      end
      S_CORR: begin
        // zero-divisor/zero-dividend paths arrive here with rem/quo cleared and no sign fixup
        result_d = {(rneg_q ? -rem_q : rem_q), (qneg_q ? -quo_q : quo_q)};
        ready_d  = 1'b1;
        dz_d     = zdiv_q;
        busy_d   = 1'b0;
        cnt_d    = '0;
        state_d  = S_END;
      end
      S_END: begin
        if (!start_i) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          result_d = '0;
          dz_d     = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      zdiv_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      zdiv_q   <= zdiv_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      dz_q     <= dz_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a 32-bit and an 8-bit instance, hand-computed results and latencies.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst, sgn, start, annul;
  logic [31:0] op1, op2;
  logic [63:0] result;
  logic        ready, busy, dz;

  logic        rst8, sgn8, start8, annul8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;
  logic        ready8, busy8, dz8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready),
    .busy_o(busy), .div_zero_o(dz)
  );

  div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .signed_div_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(result8), .ready_o(ready8),
    .busy_o(busy8), .div_zero_o(dz8)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // lat_n: cycles accept->ready without early-out; lat_e: with early-out
  task automatic do_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int lat_n, input int lat_e);
    int cyc;
    int lat;
`ifdef DIV_SEQ_EARLY_OUT_EN
    lat = lat_e;
`else
    lat = lat_n;
`endif
    @(negedge clk);
    sgn = s; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (ready) break;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_res"}, result, {er, eq});
    chk({tag, "_dz"}, 64'(dz), 64'(edz));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_hold"}, {63'(ready), 1'b0} ^ result, {63'd1, 1'b0} ^ {er, eq});
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_drop"}, {result, 62'd0} | 64'({ready, dz}), 64'd0);
  endtask

  initial begin
    int cyc;
    logic seen;
    rst = 1'b0; sgn = 1'b0; start = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
    rst8 = 1'b0; sgn8 = 1'b0; start8 = 1'b0; annul8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {result[61:0], ready, busy}, 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    @(negedge clk);
    rst = 1'b1; rst8 = 1'b1;

    do_div("u100_7",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 8);
    do_div("sm7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33, 4);
    do_div("s7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33, 4);
    do_div("sm100_m7",1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33, 8);
    do_div("u5_0",    1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          1'b1, 2, 2);
    do_div("s5_0",    1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          1'b1, 2, 2);
    do_div("smin_m1", 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33, 33);
    do_div("u0_5",    1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33, 2);

    // annul at A+10
    @(negedge clk);
    sgn = 1'b0; op1 = 32'hFFFFFFFF; op2 = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    chk("annul_busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    chk("annul_busy_after", 64'(busy), 64'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (ready || result != 64'd0) seen = 1'b1;
    end
    chk("annul_quiet", 64'(seen), 64'd0);
    do_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 5);

    // 8-bit instance
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h10; start8 = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ready8) break;
    end
    chk("w8_lat", 64'(cyc), 64'd9);
    chk("w8_res", 64'(result8), 64'h0F0F);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    chk("w8_drop", 64'({ready8, result8}), 64'd0);

    // reset mid-ON
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("w8_busy_mid", 64'(busy8), 64'd1);
    @(negedge clk);
    rst8 = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    chk("w8_rst_mid", 64'({result8, ready8, busy8, dz8}), 64'd0);
    @(negedge clk);
    rst8 = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Parametrised multi-cycle radix-2 divider. It is the next generation of the fixed 32-bit `div` unit instantiated beside `ex` in `openmips`. It accepts a start request from the execute stage and iterates one quotient bit per cycle. It returns `{remainder, quotient}` with a ready pulse-hold handshake and a divide-by-zero flag. It adds configurable width, a registered busy output, abort via annul, and optional leading-zero early termination.

## Interface
- `WIDTH`, default 32: operand width in bits; legal range 4–64.
- `clk`  in  1: clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `signed_div_i`  in  1: 1 = two's-complement operands, 0 = unsigned.
- `opdata1_i`  in  WIDTH: dividend; sampled only on accept.
- `opdata2_i`  in  WIDTH: divisor; sampled only on accept.
- `start_i`  in  1: request; level-held by `ex` until it sees `ready_o`.
- `annul_i`  in  1: abort the operation in flight; takes priority over `start_i`.
- `result_o`  out  2*WIDTH: `{remainder[WIDTH-1:0], quotient[WIDTH-1:0]}`.
- `ready_o`  out  1: result valid.
- `busy_o`  out  1: high in `BYZERO` and `ON`.
- `div_zero_o`  out  1: the current result came from a zero divisor.

## Operation
- States: `IDLE`, `BYZERO`, `ON`, `END`. Encoding is free.
- **Reset** (rst=0 at an edge): state `IDLE`, iteration counter 0. Outputs: `result_o`=0, `ready_o`=0, `busy_o`=0, `div_zero_o`=0.
- **IDLE**, acceptance:
  - Accept when `start_i`=1 and `annul_i`=0.
  - Divisor == 0 → go to `BYZERO`.
  - Otherwise latch magnitudes. In signed mode take the two's-complement absolute value of negative operands, and record `qneg` = sign1^sign2 and `rneg` = sign1. Counter ← 0, go to `ON`.
- **BYZERO**: next edge → `END` with `result_o`=0 and `div_zero_o`=1.
- **ON**, one iteration per edge:
  - Shift the partial remainder left by one and bring in the next dividend bit.
  - Trial-subtract the divisor magnitude as a WIDTH+1-bit subtraction. If there is no borrow, keep the difference and set the quotient bit to 1; otherwise set it to 0.
  - Counter increments. The edge on which the counter would reach WIDTH latches the final magnitudes and goes to `CORR`.
- **CORR** is a sub-step of `END` entry. On the edge after the last iteration:
  - `result_o` ← sign-corrected values: negate the quotient if `qneg`, negate the remainder if `rneg`.
  - `ready_o` ← 1, state `END`.
- **END**:
  - Hold `result_o` and `ready_o` while `start_i`=1.
  - When `start_i`=0: go to `IDLE` and clear `ready_o`, `result_o` and `div_zero_o` on that edge.
  - A new start cannot be accepted in the same edge as leaving `END`.
- **Annul**: `annul_i`=1 in `ON` or `BYZERO` → `IDLE` on the next edge. `ready_o` is never raised and `result_o` stays 0. Annul in `END` or `IDLE` has no effect.
- **Busy**: `start_i` and operand changes while in `ON` or `BYZERO` are ignored; there is no restart.
- **Overflow case**: signed most-negative ÷ −1 gives quotient = most-negative (wraps) and remainder 0. No flag is raised.
- Unsigned mode: no sign handling; `qneg` = `rneg` = 0.
- A nonzero remainder always has the sign of the dividend.

## Timing
- Call the accept edge A.
- Nonzero divisor, no early-out:
  - `busy_o`=1 from A+1 until the `CORR` edge.
  - `ready_o` rises after edge A+WIDTH+1. For WIDTH=32 that is 33 cycles.
- Zero divisor: `ready_o` rises after edge A+2.
- `ready_o` falls after the first edge that samples `start_i`=0 in `END`.
- Minimum back-to-back spacing between accepts: the `END`-exit edge, then at least one cycle in `IDLE`.
- Reset mid-operation aborts immediately. All outputs are at reset values after that edge.

## Configuration
- `DIV_SEQ_EARLY_OUT_EN` defined:
  - On accept, compute lz = the leading-zero count of the dividend magnitude.
  - Pre-shift the dividend magnitude left by lz and initialise the counter to lz, so there are WIDTH−lz iterations.
  - A zero dividend with nonzero divisor goes `IDLE` → `BYZERO`-like path with `div_zero_o`=0. `ready_o` rises after A+2, `result_o`=0.
- Not defined: there is always exactly WIDTH iterations, and no leading-zero logic is synthesised.
- Results are bit-identical either way; only latency differs.

## Test plan
- WIDTH=32 unsigned 100 ÷ 7 → quotient 14, remainder 2. `ready_o` rises 33 cycles after accept (8 cycles with `DIV_SEQ_EARLY_OUT_EN`: lz=25, 7 iterations).
- Signed −7 ÷ 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 ÷ −2 → quotient 0xFFFFFFFD, remainder 1.
- 5 ÷ 0 (either mode) → `div_zero_o`=1, `result_o`=0, `ready_o` after 2 cycles. Drop `start_i` → next edge `ready_o`=0 and `div_zero_o`=0.
- Signed 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0, no error flag.
- Annul asserted at A+10 → `IDLE` next edge, `busy_o`=0, `ready_o` stays 0 for 50 cycles. A fresh 9 ÷ 3 afterwards → quotient 3, remainder 0.
- WIDTH=8 unsigned 0xFF ÷ 0x10 → quotient 0x0F, remainder 0x0F, `ready_o` 9 cycles after accept. Reset asserted mid-`ON` → all outputs 0 next edge.
